// File: rtl/push_pop_sequencer.sv
// push_pop_sequencer: expands a Thumb PUSH/POP into single-register load/store micro-ops followed by an SP write-back.
// Optional macro PUSH_POP_PC_POP_EN: when defined, bit 8 of a POP list is honoured as a PC load.
module push_pop_sequencer #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LIST_WIDTH = 9,
  parameter int SP_REG_NUM = 13,
  parameter int LR_REG_NUM = 14,
  parameter int PC_REG_NUM = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  is_pop_i,
  input  logic [LIST_WIDTH-1:0] reg_list_i,
  input  logic [WORD-1:0]       stack_pointer_i,
  input  logic                  uop_ready_i,
  output logic                  uop_valid_o,
  output logic                  uop_is_load_o,
  output logic                  uop_is_sp_upd_o,
  output logic [ADDR_WIDTH-1:0] uop_reg_addr_o,
  output logic [WORD-1:0]       uop_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [1:0] {IDLE, XFER, SP_UPD} state_t;
  state_t state, state_n;
  logic [LIST_WIDTH-1:0] mask, eff_list, mask_rest;
  logic [WORD-1:0] cur_addr, new_sp, span;
  logic [ADDR_WIDTH-1:0] low_reg;
  logic is_pop, done_q, accept;
  assign accept = (state == IDLE) && start_i;
  always_comb begin
    eff_list = reg_list_i;
`ifndef PUSH_POP_PC_POP_EN
    if (is_pop_i) eff_list[LIST_WIDTH-1] = 1'b0;
`endif
    span = WORD'($countones(eff_list)) << 2;
  end
  always_comb begin
    low_reg = '0;
    for (int i = LIST_WIDTH - 1; i >= 0; i--)
      if (mask[i]) low_reg = (i == LIST_WIDTH - 1) ? (is_pop ? ADDR_WIDTH'(PC_REG_NUM) : ADDR_WIDTH'(LR_REG_NUM)) : ADDR_WIDTH'(i);
  end
  assign mask_rest = mask & (mask - LIST_WIDTH'(1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && eff_list != '0) state_n = XFER;
      XFER:    if (uop_ready_i && mask_rest == '0) state_n = SP_UPD;
      SP_UPD:  if (uop_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mask     <= '0;
      is_pop   <= 1'b0;
      cur_addr <= '0;
      new_sp   <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (accept && eff_list == '0) || (state == SP_UPD && uop_ready_i);
      if (accept) begin
        mask     <= eff_list;
        is_pop   <= is_pop_i;
        cur_addr <= is_pop_i ? stack_pointer_i : stack_pointer_i - span;
        new_sp   <= is_pop_i ? stack_pointer_i + span : stack_pointer_i - span;
      end else if (state == XFER && uop_ready_i) begin
        mask     <= mask_rest;
        cur_addr <= cur_addr + WORD'(4);
      end
    end
  end
  // Outputs decode from registered state only, so they stay stable under backpressure.
  assign uop_valid_o     = state != IDLE;
  assign uop_is_load_o   = (state == XFER) && is_pop;
  assign uop_is_sp_upd_o = state == SP_UPD;
  assign uop_reg_addr_o  = (state == XFER) ? low_reg : (state == SP_UPD) ? ADDR_WIDTH'(SP_REG_NUM) : '0;
  assign uop_addr_o      = (state == XFER) ? cur_addr : (state == SP_UPD) ? new_sp : '0;
  assign busy_o          = state != IDLE;
  assign done_o          = done_q;
endmodule

// File: tb/tb_push_pop_sequencer.sv
// tb_push_pop_sequencer: directed and randomized PUSH/POP runs checked against a list-expansion model.
module tb_push_pop_sequencer;
`ifdef PUSH_POP_PC_POP_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif
  typedef struct {
    logic        ld;
    logic        spu;
    logic [3:0]  r;
    logic [31:0] a;
  } uop_t;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, is_pop_i = 1'b0, uop_ready_i = 1'b0;
  logic [8:0] reg_list_i = '0;
  logic [31:0] stack_pointer_i = '0;
  logic uop_valid_o, uop_is_load_o, uop_is_sp_upd_o, busy_o, done_o;
  logic [3:0] uop_reg_addr_o;
  logic [31:0] uop_addr_o;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  push_pop_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .is_pop_i(is_pop_i),
    .reg_list_i(reg_list_i), .stack_pointer_i(stack_pointer_i), .uop_ready_i(uop_ready_i),
    .uop_valid_o(uop_valid_o), .uop_is_load_o(uop_is_load_o), .uop_is_sp_upd_o(uop_is_sp_upd_o),
    .uop_reg_addr_o(uop_reg_addr_o), .uop_addr_o(uop_addr_o), .busy_o(busy_o), .done_o(done_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, uop_valid_o, 0);
    chk({tag, "_load"}, uop_is_load_o, 0);
    chk({tag, "_spu"}, uop_is_sp_upd_o, 0);
    chk({tag, "_reg"}, uop_reg_addr_o, 0);
    chk({tag, "_addr"}, uop_addr_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask
  // stall bit i forces ready low on issuing cycle i; glitch is the cycle a stray start is pulsed
  task automatic run_op(input logic pop, input logic [8:0] list, input logic [31:0] sp, input int rdy_pct,
                        input logic [31:0] stall, input int glitch, input int rst_after);
    uop_t q[$];
    uop_t u;
    int n = 0, k = 0, guard = 0, acc = 0;
    logic [31:0] base;
    bit aborted = 0;
    for (int r = 0; r < 9; r++) if (list[r] && (r < 8 || !pop || PC_EN)) n++;
    base = pop ? sp : sp - 32'(4 * n);
    for (int r = 0; r < 9; r++)
      if (list[r] && (r < 8 || !pop || PC_EN)) begin
        u.ld = pop;
        u.spu = 1'b0;
        u.r = (r == 8) ? (pop ? 4'd15 : 4'd14) : 4'(r);
        u.a = base + 32'(4 * k);
        q.push_back(u);
        k++;
      end
    if (n > 0) begin
      u.ld = 1'b0;
      u.spu = 1'b1;
      u.r = 4'd13;
      u.a = pop ? sp + 32'(4 * n) : sp - 32'(4 * n);
      q.push_back(u);
    end
    @(negedge clk_i);
    start_i = 1'b1;
    is_pop_i = pop;
    reg_list_i = list;
    stack_pointer_i = sp;
    @(negedge clk_i);
    start_i = 1'b0;
    while (q.size() > 0 && guard < 300) begin
      if (acc == rst_after) begin
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_idle("rst_mid");
        chk("rst_mid_done", done_o, 0);
        rst_i = 1'b0;
        q.delete();
        aborted = 1;
        break;
      end
      uop_ready_i = (guard < 32 && stall[guard]) ? 1'b0 : 1'($urandom_range(99) < rdy_pct);
      start_i = (guard == glitch);
      if (start_i) begin
        reg_list_i = 9'($urandom);
        is_pop_i = 1'($urandom);
        stack_pointer_i = $urandom;
      end
      chk("valid", uop_valid_o, 1);
      chk("busy", busy_o, 1);
      chk("done_early", done_o, 0);
      chk("load", uop_is_load_o, q[0].ld);
      chk("spu", uop_is_sp_upd_o, q[0].spu);
      chk("reg", uop_reg_addr_o, q[0].r);
      chk("addr", uop_addr_o, q[0].a);
      @(posedge clk_i);
      if (uop_ready_i) begin
        void'(q.pop_front());
        acc++;
      end
      @(negedge clk_i);
      guard++;
    end
    start_i = 1'b0;
    uop_ready_i = 1'b0;
    if (q.size() > 0) chk("timeout_pending", q.size(), 0);
    if (!aborted) begin
      chk("done_pulse", done_o, 1);
      chk_idle("after");
    end
    @(negedge clk_i);
    chk("done_single", done_o, 0);
    chk_idle("settled");
  endtask
  initial begin
    repeat (2) @(negedge clk_i);
    chk_idle("reset");
    chk("reset_done", done_o, 0);
    rst_i = 1'b0;
    run_op(1'b0, 9'h105, 32'h100, 100, 0, -1, -1);
    run_op(1'b1, 9'h00A, 32'h200, 100, 0, -1, -1);
    run_op(1'b0, 9'h020, 32'h40, 100, 32'h7, 1, -1);
    run_op(1'b0, 9'h000, 32'h1234, 100, 0, -1, -1);
    run_op(1'b1, 9'h0FF, 32'h100, 100, 0, -1, 3);
    run_op(1'b0, 9'h010, 32'h300, 100, 0, -1, -1);
    run_op(1'b1, 9'h180, 32'h80, 100, 0, -1, -1);
    run_op(1'b1, 9'h100, 32'h90, 100, 0, -1, -1);
    run_op(1'b0, 9'h1FF, 32'h10, 60, 0, 2, -1);
    run_op(1'b1, 9'h1FF, 32'hFFFF_FFF8, 70, 0, -1, -1);
    for (int t = 0; t < 40; t++)
      run_op(1'($urandom), ($urandom_range(7) == 0) ? 9'h0 : 9'($urandom), $urandom,
             $urandom_range(30, 100), 0, $urandom_range(0, 5),
             ($urandom_range(7) == 0) ? $urandom_range(0, 3) : -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
